// File: rtl/video_stream_gen_pkg.sv
// Shared definitions for the video stream generator: default raster timing,
// pixel and counter widths, FSM state type and a sync-window helper.
package video_pkg;

  localparam int PIX_W = 8;
  localparam int CNT_W = 10;

  localparam int H_TOTAL_DEF      = 800;
  localparam int H_ACTIVE_DEF     = 640;
  localparam int H_SYNC_START_DEF = 656;
  localparam int H_SYNC_LEN_DEF   = 96;
  localparam int V_TOTAL_DEF      = 525;
  localparam int V_ACTIVE_DEF     = 480;
  localparam int V_SYNC_START_DEF = 490;
  localparam int V_SYNC_LEN_DEF   = 2;
  localparam int FIFO_DEPTH_DEF   = 16;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } vsg_state_e;

  // True when start <= cnt < start+len; the end is computed one bit wider
  // so a window touching the top of the counter range cannot wrap.
  function automatic logic in_window(input cnt_t cnt, input cnt_t start, input cnt_t len);
    logic [CNT_W:0] stop_x;
    stop_x = {1'b0, start} + {1'b0, len};
    return (cnt >= start) && ({1'b0, cnt} < stop_x);
  endfunction

endpackage

// File: rtl/video_stream_gen_if.sv
// Upstream pixel ready/valid channel feeding the video stream generator.
interface video_stream_gen_if;
  import video_pkg::*;

  pix_t iPixData;
  logic iPixValid;
  logic oPixReady;

  modport master (output iPixData, output iPixValid, input oPixReady);
  modport slave  (input iPixData, input iPixValid, output oPixReady);
endinterface

// File: rtl/video_stream_gen_pix_fifo.sv
// pix_fifo: synchronous show-ahead FIFO. dout always presents the oldest
// entry; a pop on an empty FIFO is ignored. A push while full is accepted
// only when a pop in the same cycle frees the slot.
module pix_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // Next pointers, occupancy and registered full/empty flags
  always_comb begin
    do_pop   = pop & ~empty_q;
    do_push  = push & (~full_q | do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
  end

  // Control state; reset discards all contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/video_stream_gen.sv
// video_stream_gen: raster timing generator with a pixel FIFO front end.
// Free-running h/v counters drive registered sync/valid outputs one clock
// after the counter value; active cycles pop one pixel from the FIFO.
// Optional build macro VSG_TEST_PATTERN_EN adds iPatternSel, which replaces
// FIFO pixels with hCnt^vCnt for a whole frame.
module video_stream_gen
  import video_pkg::*;
#(
  parameter int H_TOTAL      = H_TOTAL_DEF,
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int H_SYNC_START = H_SYNC_START_DEF,
  parameter int H_SYNC_LEN   = H_SYNC_LEN_DEF,
  parameter int V_TOTAL      = V_TOTAL_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int V_SYNC_START = V_SYNC_START_DEF,
  parameter int V_SYNC_LEN   = V_SYNC_LEN_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iEnable,
`ifdef VSG_TEST_PATTERN_EN
  input  logic               iPatternSel,
`endif
  video_stream_gen_if.slave  pix_if,
  output logic [PIX_W-1:0]   oY,
  output logic               oHSync,
  output logic               oVSync,
  output logic               oLineValid,
  output logic               oFrameValid,
  output logic               oUnderflow
);
  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT  = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT  = cnt_t'(V_ACTIVE);
  localparam cnt_t H_SS   = cnt_t'(H_SYNC_START);
  localparam cnt_t H_SL   = cnt_t'(H_SYNC_LEN);
  localparam cnt_t V_SS   = cnt_t'(V_SYNC_START);
  localparam cnt_t V_SL   = cnt_t'(V_SYNC_LEN);

  vsg_state_e state_q, state_d;
  cnt_t       hcnt_q, hcnt_d;
  cnt_t       vcnt_q, vcnt_d;
  logic       pat_q, pat_d;
  pix_t       y_q, y_d;
  logic       hs_q, hs_d, vs_q, vs_d;
  logic       lv_q, lv_d, fv_q, fv_d;
  logic       uf_q, uf_d;

  logic       counting, frame_end, frame_start, active;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  pix_t       fifo_dout;

  assign counting    = (state_q != ST_IDLE);
  assign frame_end   = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
  assign frame_start = ((state_q == ST_IDLE) && iEnable) || (counting && frame_end);
  assign active      = counting && (hcnt_q < H_ACT) && (vcnt_q < V_ACT);

  assign fifo_push        = pix_if.iPixValid & pix_if.oPixReady;
  assign pix_if.oPixReady = ~fifo_full;

  pix_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (iClk),
    .rst_n (iRst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (pix_if.iPixData),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Run/stop FSM and raster counters; counters sit at 0 while idle
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    unique case (state_q)
      ST_IDLE: if (iEnable) state_d = ST_RUN;
      ST_RUN:  if (!iEnable) state_d = ST_STOP;
      ST_STOP: begin
        if (iEnable)        state_d = ST_RUN;
        else if (frame_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (counting) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + cnt_t'(1);
      end else begin
        hcnt_d = hcnt_q + cnt_t'(1);
      end
    end else begin
      hcnt_d = '0;
      vcnt_d = '0;
    end
  end

  // Output decode: timing from counters, pixel from FIFO or test pattern
  always_comb begin
`ifdef VSG_TEST_PATTERN_EN
    pat_d = frame_start ? iPatternSel : pat_q;
`else
    pat_d = 1'b0;
`endif
    fifo_pop = active & ~pat_q & ~fifo_empty;
    y_d      = '0;
    if (active) begin
      if (pat_q)            y_d = hcnt_q[7:0] ^ vcnt_q[7:0];
      else if (!fifo_empty) y_d = fifo_dout;
    end
    lv_d = active;
    fv_d = counting && (vcnt_q < V_ACT);
    hs_d = counting && in_window(hcnt_q, H_SS, H_SL);
    vs_d = counting && in_window(vcnt_q, V_SS, V_SL);
    uf_d = uf_q;
    if ((state_q == ST_IDLE) && iEnable)   uf_d = 1'b0;
    else if (active && !pat_q && fifo_empty) uf_d = 1'b1;
  end

  // FSM state and counter registers
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= ST_IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      pat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      pat_q   <= pat_d;
    end
  end

  // Registered outputs, one clock behind the counters
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      y_q  <= '0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      lv_q <= 1'b0;
      fv_q <= 1'b0;
      uf_q <= 1'b0;
    end else begin
      y_q  <= y_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      lv_q <= lv_d;
      fv_q <= fv_d;
      uf_q <= uf_d;
    end
  end

  assign oY          = y_q;
  assign oHSync      = hs_q;
  assign oVSync      = vs_q;
  assign oLineValid  = lv_q;
  assign oFrameValid = fv_q;
  assign oUnderflow  = uf_q;

endmodule
